// File: rtl/tri_seq_pkg.sv
// tri_seq_pkg
//   Shared types and helpers for the triangle-sequence checker family.
//   - tri_state_e : checker FSM states (SEARCH, ACQUIRE, LOCKED)
//   - DIR_UP / DIR_DOWN : direction encoding (0 ascending, 1 descending)
//   - tri_next()  : successor of a triangle sample, including the turn at
//                   the top (MAX) and bottom (0) of the ramp
package tri_seq_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } tri_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Width-agnostic successor: callers widen their sample to 32 bits and
  // pass the ramp maximum. Returns {new_dir, next_value}.
  function automatic logic [32:0] tri_next(input logic [31:0] p,
                                           input logic        d,
                                           input logic [31:0] max_v);
    logic [31:0] v;
    logic        nd;
    nd = d;
    if (d == DIR_UP && p == max_v) begin
      v  = max_v - 32'd1;
      nd = DIR_DOWN;
    end else if (d == DIR_DOWN && p == 32'd0) begin
      v  = 32'd1;
      nd = DIR_UP;
    end else if (d == DIR_UP) begin
      v = p + 32'd1;
    end else begin
      v = p - 32'd1;
    end
    return {nd, v};
  endfunction

endpackage

// File: rtl/tri_seq_next.sv
// tri_seq_next
//   Combinational next-expected / next-direction calculator for a
//   WIDTH-bit triangle ramp (0..2**WIDTH-1..0). Intended to be shared by the
//   checker and a future regenerator. WIDTH must be below 31.
//   Ports:
//     p_i   in  WIDTH  current sample
//     d_i   in  1      direction of the step that produced p_i
//     val_o out WIDTH  successor of p_i
//     dir_o out 1      direction of the step from p_i to val_o
module tri_seq_next
  import tri_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] val_o,
  output logic             dir_o
);

  localparam logic [31:0] MAX_V = 32'((1 << WIDTH) - 1);

  logic [32:0] res;
  logic        unused_hi;

  assign res       = tri_next(32'(p_i), d_i, MAX_V);
  assign val_o     = res[WIDTH-1:0];
  assign dir_o     = res[32];
  // Upper value bits are always zero for an in-range sample.
  assign unused_hi = ^res[31:WIDTH];

endmodule

// File: rtl/tri_seq_checker.sv
// tri_seq_checker
//   Receive-side monitor for the triangle sequencer stream. Acquires lock
//   after LOCK_COUNT consecutive legal successors, then tracks the expected
//   value/direction, flags deviations and reports peak/trough events.
//   Optional feature macro: TRI_CHK_ERR_CNT_EN (error counter present; when
//   undefined err_count is tied to 0 and no counter flops exist).
//   Ports:
//     clk          in  1      clock, rising edge
//     reset        in  1      synchronous, active-low
//     in_valid     in  1      sample strobe
//     in_data      in  WIDTH  sample value
//     locked       out 1      pattern lock indicator
//     dir          out 1      tracked direction (0 up, 1 down)
//     expected     out WIDTH  next value expected
//     err_pulse    out 1      one-cycle pulse on mismatch while locked
//     peak_pulse   out 1      one-cycle pulse on accepted locked MAX
//     trough_pulse out 1      one-cycle pulse on accepted locked 0
//     err_count    out ERR_W  saturating error count
//     dbg_state    out 2      current FSM state
//   Handshake: a sample is consumed on every rising edge where in_valid is
//   high; there is no backpressure. Cycles with in_valid low leave all
//   state untouched and only clear the pulses.
module tri_seq_checker
  import tri_seq_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             dir,
  output logic [WIDTH-1:0] expected,
  output logic             err_pulse,
  output logic             peak_pulse,
  output logic             trough_pulse,
  output logic [ERR_W-1:0] err_count,
  output tri_state_e       dbg_state
);

  localparam logic [WIDTH-1:0] MAX_V = {WIDTH{1'b1}};
  localparam int               CW    = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0]    LOCK_LAST = CW'(LOCK_COUNT - 1);

  tri_state_e       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             peak_q, peak_d;
  logic             trough_q, trough_d;

  // Direction of the step that produced the accepted sample, and whether
  // this cycle accepts a legal step (which refreshes dir).
  logic             step_dir;
  logic             dir_upd;
  logic             legal;
  logic [WIDTH-1:0] prev_inc, prev_dec;
  logic [WIDTH-1:0] nxt_val;
  logic             nxt_dir;

  assign prev_inc = prev_q + WIDTH'(1);
  assign prev_dec = prev_q - WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    peak_d   = 1'b0;
    trough_d = 1'b0;
    step_dir = dir_q;
    dir_upd  = 1'b0;
    legal    = 1'b0;
    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          prev_d  = in_data;
          cnt_d   = '0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (cnt_q == '0) begin
            // First step fixes the direction; no wrap across 0/MAX.
            if (prev_q != MAX_V && in_data == prev_inc) begin
              legal    = 1'b1;
              step_dir = DIR_UP;
            end else if (prev_q != '0 && in_data == prev_dec) begin
              legal    = 1'b1;
              step_dir = DIR_DOWN;
            end
          end else begin
            legal = (in_data == exp_q);
          end
          prev_d = in_data;
          if (legal) begin
            dir_upd = 1'b1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LOCK_LAST) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        LOCKED: begin
          prev_d = in_data;
          if (in_data == exp_q) begin
            dir_upd  = 1'b1;
            peak_d   = (in_data == MAX_V);
            trough_d = (in_data == '0);
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            cnt_d    = '0;
            state_d  = ACQUIRE;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // The stored dir is the direction toward the expected value, so it turns
  // as soon as MAX or 0 is accepted rather than one sample later.
  tri_seq_next #(.WIDTH(WIDTH)) u_next (
    .p_i   (prev_d),
    .d_i   (step_dir),
    .val_o (nxt_val),
    .dir_o (nxt_dir)
  );

  assign dir_d = dir_upd ? nxt_dir : dir_q;
  assign exp_d = in_valid ? nxt_val : exp_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= SEARCH;
      prev_q   <= '0;
      cnt_q    <= '0;
      dir_q    <= DIR_UP;
      exp_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      peak_q   <= 1'b0;
      trough_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      exp_q    <= exp_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      peak_q   <= peak_d;
      trough_q <= trough_d;
    end
  end

`ifdef TRI_CHK_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else if (err_d && err_cnt_q != {ERR_W{1'b1}}) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

  assign locked       = locked_q;
  assign dir          = dir_q;
  assign expected     = exp_q;
  assign err_pulse    = err_q;
  assign peak_pulse   = peak_q;
  assign trough_pulse = trough_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_tri_seq_checker.sv
// tb_tri_seq_checker
//   Directed bench for tri_seq_checker: a table of per-cycle vectors with
//   hand-computed expected outputs, followed by hand-written sequences for
//   gapped input, reset during lock and error-counter saturation.
module tb_tri_seq_checker;
  import tri_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       locked, dir, err_pulse, peak_pulse, trough_pulse;
  logic [3:0] expected;
  logic [7:0] err_count;
  tri_state_e dbg_state;

  always #5 clk = ~clk;

  tri_seq_checker dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .locked       (locked),
    .dir          (dir),
    .expected     (expected),
    .err_pulse    (err_pulse),
    .peak_pulse   (peak_pulse),
    .trough_pulse (trough_pulse),
    .err_count    (err_count),
    .dbg_state    (dbg_state)
  );

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst_n;
    logic       v;
    logic [3:0] d;
    logic       lk;
    logic       dr;
    logic [3:0] ex;
    logic       er;
    logic       pk;
    logic       tr;
    logic [7:0] ec;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  // Error count is only visible when the counter is built in.
  function automatic logic [7:0] ecv(input int n);
`ifdef TRI_CHK_ERR_CNT_EN
    return 8'(n);
`else
    return 8'(0 * n);
`endif
  endfunction

  function automatic void add(input logic r, input logic v, input int d,
                              input logic lk, input logic dr, input int ex,
                              input logic er, input logic pk, input logic tr,
                              input int ec, input tri_state_e st);
    vec_t t;
    t.rst_n = r;  t.v = v;   t.d = 4'(d);
    t.lk = lk;    t.dr = dr; t.ex = 4'(ex);
    t.er = er;    t.pk = pk; t.tr = tr;
    t.ec = ecv(ec);
    t.st = st;
    vecs.push_back(t);
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic apply(input logic r, input logic v, input logic [3:0] d);
    @(negedge clk);
    reset    = r;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, req);
    end
  endtask

  task automatic check_all(input int idx, input vec_t t);
    check("locked", idx, int'(locked), int'(t.lk));
    check("dir", idx, int'(dir), int'(t.dr));
    check("expected", idx, int'(expected), int'(t.ex));
    check("err_pulse", idx, int'(err_pulse), int'(t.er));
    check("peak_pulse", idx, int'(peak_pulse), int'(t.pk));
    check("trough_pulse", idx, int'(trough_pulse), int'(t.tr));
    check("err_count", idx, int'(err_count), int'(t.ec));
    check("state", idx, int'(dbg_state), int'(t.st));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seq[$];
    // Reset, then ramp 0,1,2,3 -> lock after sample 3.
    add(0,1,5,  0,0,0,  0,0,0,0, SEARCH);
    add(1,1,0,  0,0,1,  0,0,0,0, ACQUIRE);
    add(1,1,1,  0,0,2,  0,0,0,0, ACQUIRE);
    add(1,1,2,  0,0,3,  0,0,0,0, ACQUIRE);
    add(1,1,3,  1,0,4,  0,0,0,0, LOCKED);
    // Full period: peak at 15, trough at 0.
    for (int d = 4; d <= 14; d++) add(1,1,d, 1,0,d+1, 0,0,0,0, LOCKED);
    add(1,1,15, 1,1,14, 0,1,0,0, LOCKED);
    for (int d = 14; d >= 1; d--) add(1,1,d, 1,1,d-1, 0,0,0,0, LOCKED);
    add(1,1,0,  1,0,1,  0,0,1,0, LOCKED);
    for (int d = 1; d <= 7; d++) add(1,1,d, 1,0,d+1, 0,0,0,0, LOCKED);
    // Inject 9 where 8 is expected, then relock on 10,11,12.
    add(1,1,9,  0,0,10, 1,0,0,1, ACQUIRE);
    add(1,1,10, 0,0,11, 0,0,0,1, ACQUIRE);
    add(1,1,11, 0,0,12, 0,0,0,1, ACQUIRE);
    add(1,1,12, 1,0,13, 0,0,0,1, LOCKED);
    add(1,0,3,  1,0,13, 0,0,0,1, LOCKED);
    add(1,1,13, 1,0,14, 0,0,0,1, LOCKED);
    add(1,1,14, 1,0,15, 0,0,0,1, LOCKED);
    add(1,1,15, 1,1,14, 0,1,0,1, LOCKED);
    add(1,0,15, 1,1,14, 0,0,0,1, LOCKED);
    // Reset, then 15,0 is no legal step; lock on 0,1,2,3.
    add(0,1,7,  0,0,0,  0,0,0,0, SEARCH);
    add(1,1,15, 0,0,14, 0,0,0,0, ACQUIRE);
    add(1,1,0,  0,0,1,  0,0,0,0, ACQUIRE);
    add(1,1,1,  0,0,2,  0,0,0,0, ACQUIRE);
    add(1,1,2,  0,0,3,  0,0,0,0, ACQUIRE);
    add(1,1,3,  1,0,4,  0,0,0,0, LOCKED);
    // Descending acquisition and a locked mismatch while descending.
    add(0,0,0,  0,0,0,  0,0,0,0, SEARCH);
    add(1,1,10, 0,0,11, 0,0,0,0, ACQUIRE);
    add(1,1,9,  0,1,8,  0,0,0,0, ACQUIRE);
    add(1,1,8,  0,1,7,  0,0,0,0, ACQUIRE);
    add(1,1,7,  1,1,6,  0,0,0,0, LOCKED);
    add(1,1,6,  1,1,5,  0,0,0,0, LOCKED);
    add(1,1,6,  0,1,5,  1,0,0,1, ACQUIRE);
    // Acquisition across the top turn: 13,14,15,14.
    add(0,1,0,  0,0,0,  0,0,0,0, SEARCH);
    add(1,1,13, 0,0,14, 0,0,0,0, ACQUIRE);
    add(1,1,14, 0,0,15, 0,0,0,0, ACQUIRE);
    add(1,1,15, 0,1,14, 0,0,0,0, ACQUIRE);
    add(1,1,14, 1,1,13, 0,0,0,0, LOCKED);
    // 0 -> 15 is no legal step; acquisition restarts from 15 descending.
    add(0,1,0,  0,0,0,  0,0,0,0, SEARCH);
    add(1,1,0,  0,0,1,  0,0,0,0, ACQUIRE);
    add(1,1,15, 0,0,14, 0,0,0,0, ACQUIRE);
    add(1,1,14, 0,1,13, 0,0,0,0, ACQUIRE);
    add(1,1,13, 0,1,12, 0,0,0,0, ACQUIRE);
    add(1,1,12, 1,1,11, 0,0,0,0, LOCKED);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst_n, vecs[i].v, vecs[i].d);
      check_all(i, vecs[i]);
    end

    // Gapped input: valid toggles every cycle, state holds across gaps.
    apply(0, 0, 4'd0);
    for (int d = 0; d <= 3; d++) apply(1, 1, 4'(d));
    check("gap_lock", 0, int'(locked), 1);
    for (int d = 4; d <= 15; d++) seq.push_back(d);
    for (int d = 14; d >= 8; d--) seq.push_back(d);
    for (int i = 0; i + 1 < seq.size(); i++) begin
      exp_q.push_back(4'(seq[i+1]));
      apply(1, 1, 4'(seq[i]));
      check("gap_expected", i, int'(expected), int'(exp_q[0]));
      check("gap_dir", i, int'(dir), (seq[i+1] < seq[i]) ? 1 : 0);
      check("gap_peak", i, int'(peak_pulse), (seq[i] == 15) ? 1 : 0);
      check("gap_err", i, int'(err_pulse), 0);
      apply(1, 0, 4'($urandom_range(0, 15)));
      check("gap_hold_expected", i, int'(expected), int'(exp_q.pop_front()));
      check("gap_hold_locked", i, int'(locked), 1);
      check("gap_hold_peak", i, int'(peak_pulse), 0);
    end

    // Reset during lock with a valid, correct sample present.
    apply(0, 1, 4'd7);
    check("rst_locked", 0, int'(locked), 0);
    check("rst_expected", 0, int'(expected), 0);
    check("rst_dir", 0, int'(dir), 0);
    check("rst_err_count", 0, int'(err_count), 0);
    check("rst_state", 0, int'(dbg_state), int'(SEARCH));

    // Repeated lock/mismatch cycles drive the error counter into saturation.
    for (int d = 0; d <= 3; d++) apply(1, 1, 4'(d));
    for (int i = 0; i < 300; i++) begin
      apply(1, 1, 4'd0);
      if (i == 0) begin
        check("sat_first_err", i, int'(err_pulse), 1);
        check("sat_first_count", i, int'(err_count), int'(ecv(1)));
      end
      for (int d = 1; d <= 3; d++) apply(1, 1, 4'(d));
    end
    check("sat_count", 0, int'(err_count), int'(ecv(255)));
    check("sat_locked", 0, int'(locked), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tri_seq_checker.md
# tri_seq_checker

Receive-side checker for the 4-bit triangle sequencer stream (0 1 2 … 14 15 14 … 1 0 1 …). It samples a data word qualified by a valid strobe and acquires lock on the triangle pattern. Once locked, it tracks the expected value and direction, flags every deviation, and reports peak and trough events. It sits directly downstream of the up/down sequencer, or of any link carrying its output, as a board-level self-test monitor.

## Interface
Parameters:
- WIDTH, 4, sample width; MAX = 2**WIDTH-1
- LOCK_COUNT, 3, consecutive legal successors required to lock (≥1)
- ERR_W, 8, width of error counter

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- in_valid  in  1  sample strobe; one sample per cycle while high
- in_data  in  WIDTH  sample value
- locked  out  1  pattern lock indicator
- dir  out  1  tracked direction: 0 ascending, 1 descending
- expected  out  WIDTH  next value expected (meaningful while locked)
- err_pulse  out  1  one-cycle pulse on mismatch while locked
- peak_pulse  out  1  one-cycle pulse when accepted locked sample == MAX
- trough_pulse  out  1  one-cycle pulse when accepted locked sample == 0
- err_count  out  ERR_W  saturating count of err_pulse events

## Operation
- States: SEARCH, ACQUIRE, LOCKED. Internal regs: prev (WIDTH), match_cnt, dir.
- in_valid low: no state, register or output change except pulses, which clear to 0.
- SEARCH + valid: prev ← in_data, match_cnt ← 0 → ACQUIRE.
- ACQUIRE + valid, match_cnt==0: legal iff in_data == prev+1 with prev≠MAX (dir ← 0), or in_data == prev−1 with prev≠0 (dir ← 1). No modular wrap: 15→0 and 0→15 are illegal.
- ACQUIRE + valid, match_cnt>0: legal iff in_data == next(prev,dir).
- Legal in ACQUIRE: prev ← in_data, match_cnt+1; on reaching LOCK_COUNT → LOCKED, locked ← 1. Illegal in ACQUIRE: prev ← in_data, match_cnt ← 0. No err_pulse.
- next(p,d): d=0 and p==MAX → MAX−1, dir becomes 1; d=1 and p==0 → 1, dir becomes 0; otherwise p+1 when ascending, p−1 when descending.
- LOCKED + valid, in_data == expected: prev ← in_data, dir updated per next(); peak_pulse if in_data==MAX; trough_pulse if in_data==0.
- LOCKED + valid, mismatch: err_pulse ← 1, err_count+1 (saturates at 2**ERR_W−1), locked ← 0, prev ← in_data, match_cnt ← 0 → ACQUIRE.
- expected = next(prev,dir), registered and updated with prev/dir.
- Reset (low at edge) in any state: → SEARCH, locked=0, dir=0, expected=0, all pulses 0, err_count=0, prev=0, match_cnt=0. Reset overrides in_valid.

## Timing
- All outputs registered; the response to a sample appears on the edge that captures it, visible the following cycle.
- Lock latency from SEARCH: LOCK_COUNT+1 valid samples; locked rises after the edge capturing the (LOCK_COUNT+1)th.
- Pulses last exactly one cycle; back-to-back valid samples may produce pulses on consecutive cycles.
- Gaps in in_valid are transparent: the sequence continues across gaps.

## Configuration
- TRI_CHK_ERR_CNT_EN defined: err_count register and saturation logic present.
- Undefined: err_count tied to 0, and no counter flops are synthesized. err_pulse and all other behaviour are unchanged.

## Structure
- Package tri_seq_pkg: state enum type (SEARCH, ACQUIRE, LOCKED), direction constants DIR_UP/DIR_DOWN, and a parameterized function for next(p,d).
- One sub-module, tri_seq_next: combinational next-expected/next-direction calculator, shared with a future regenerator. The FSM, counters and pulses stay in the top module.

## Test plan
- Reset, then feed 0,1,2,3,… continuously → locked rises after the sample 3 edge; dir=0; expected=4.
- Locked through a full period 0→15→0 → one peak_pulse at 15, dir flips to 1 after 15, trough_pulse at 0, err_count stays 0.
- Locked at 7 ascending, inject 9 → err_pulse one cycle, locked=0, err_count=1; resume 10,11,12 → relock after 12.
- From SEARCH feed 15,0,1,2 → 15→0 rejected; locked only after 0,1,2,3 (sample 3).
- Locked, in_valid toggling 1/0 each cycle with the correct sequence → no errors; state is held during gaps.
- Reset low mid-lock with in_valid=1 → next cycle locked=0, err_count=0, expected=0, state SEARCH.
